// File: rtl/value_change_counter.sv
// Counts value changes of a sampled signal over fixed windows of valid samples.
// Each closed window's count is offered on a valid/ready report port.
module value_change_counter #(
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int DROP_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample_in,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [CNT_W-1:0]  report_count,
    output logic              report_sat,
    output logic [DROP_W-1:0] drop_count,
    output logic              baseline_ok
);

    localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    typedef enum logic {EMPTY = 1'b0, ARMED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              win_sat_q, win_sat_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
    logic              rpt_sat_q, rpt_sat_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              chg;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  cnt_new;
    logic              sat_new;
    logic              xfer;
    logic              close;

    // The first sample after reset/clear has no prior value, so it always counts.
    assign chg     = (state_q == EMPTY) || (sample_in != last_q);
    assign sum     = {1'b0, win_cnt_q} + {{CNT_W{1'b0}}, chg};
    assign cnt_new = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign sat_new = win_sat_q | sum[CNT_W];
    assign xfer    = rpt_valid_q && report_ready;
    assign close   = sample_valid && (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        win_cnt_d   = win_cnt_q;
        win_sat_d   = win_sat_q;
        rpt_valid_d = rpt_valid_q;
        rpt_count_d = rpt_count_q;
        rpt_sat_d   = rpt_sat_q;
        drop_d      = drop_q;
        if (clear) begin
            state_d     = EMPTY;
            idx_d       = '0;
            win_cnt_d   = '0;
            win_sat_d   = 1'b0;
            rpt_valid_d = 1'b0;
        end else begin
            if (xfer) rpt_valid_d = 1'b0;
            if (sample_valid) begin
                state_d = ARMED;
                last_d  = sample_in;
                if (close) begin
                    idx_d     = '0;
                    win_cnt_d = '0;
                    win_sat_d = 1'b0;
                    // A pending, non-transferring report wins; the new result is lost.
                    if (!rpt_valid_q || xfer) begin
                        rpt_valid_d = 1'b1;
                        rpt_count_d = cnt_new;
                        rpt_sat_d   = sat_new;
                    end else if (drop_q != {DROP_W{1'b1}}) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    win_cnt_d = cnt_new;
                    win_sat_d = sat_new;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            last_q      <= '0;
            idx_q       <= '0;
            win_cnt_q   <= '0;
            win_sat_q   <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_count_q <= '0;
            rpt_sat_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            win_cnt_q   <= win_cnt_d;
            win_sat_q   <= win_sat_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_count_q <= rpt_count_d;
            rpt_sat_q   <= rpt_sat_d;
            drop_q      <= drop_d;
        end
    end

    assign report_valid = rpt_valid_q;
    assign report_count = rpt_count_q;
    assign report_sat   = rpt_sat_q;
    assign drop_count   = drop_q;
    assign baseline_ok  = (state_q == ARMED);

endmodule
